accum_ctrl: RTL
===============

# accum_ctrl

Sequential accumulate controller that sits around the team's generic K-bit ripple-carry adder (`full_adder`). It accepts a stream of unsigned operands over a valid/ready handshake and drives the adder's `a`/`b` inputs from its running accumulator and the incoming operand. It registers the adder's `sum`/`overflow` back into the accumulator and presents the burst total, with a sticky carry-out flag, on a valid/ready output port. The adder is instantiated outside this block; `accum_ctrl` is the stage immediately upstream (feeding operands) and downstream (consuming results) of it.

## Interface
- `K`, 8, operand/accumulator width; must equal the `K` of the attached `full_adder`.
- `MAX_CNT`, 16, maximum operands per burst, ≥1.
- `CNT_W`, $clog2(MAX_CNT+1), beat-counter width.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  K  unsigned operand.
- `in_last`  in  1  final beat of burst (qualified by `in_valid`).
- `add_a`  out  K  to adder `a`.
- `add_b`  out  K  to adder `b`.
- `add_sum`  in  K  from adder `sum`.
- `add_cout`  in  1  from adder `overflow`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  K  burst total modulo 2^K.
- `out_ovf`  out  1  1 if any accumulation step produced carry-out.
- `out_count`  out  CNT_W  beats accepted in burst.
- `out_trunc`  out  1  burst closed by `MAX_CNT`, not by `in_last`.

## Operation
- FSM states: IDLE (no beats yet), ACC (≥1 beat accepted, burst open), DONE (result held).
- Beat accepted ("fire") when `in_valid && in_ready`.
- `in_ready` = !`rst` && state != DONE (combinational).
- `add_a` = 0 in IDLE, else `acc`; `add_b` = `in_data` (combinational, always driven).
- On fire: `acc` <= `add_sum`; `ovf` <= `ovf` | `add_cout` (IDLE: `ovf` <= `add_cout`); `count` <= `count`+1 (IDLE: 1).
- Transitions on fire: if `in_last` or new count == `MAX_CNT` → DONE, else → ACC. `trunc` <= (new count == `MAX_CNT`) && !`in_last`.
- DONE: `out_valid`=1; `out_sum`/`out_ovf`/`out_count`/`out_trunc` reflect registers and hold stable until accepted.
- DONE and `out_ready` → IDLE; `acc`, `ovf`, `count`, `trunc` cleared same edge.
- No fire in IDLE/ACC: state and registers hold.
- Arithmetic: unsigned, modulo 2^K; `ovf` is sticky within a burst, never cleared mid-burst.
- Beats arriving after a `MAX_CNT` truncation belong to the next burst; none are dropped (backpressured while DONE).

## Timing
- Reset (`rst`=1 at edge): state IDLE, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_count`=0, `out_trunc`=0; `in_ready`=0 while `rst` high, 1 the cycle after release.
- Reset mid-burst or in DONE: all state discarded; no result emitted.
- Latency: `out_valid` rises the cycle after the closing beat fires.
- Minimum burst period: beats + 1 cycle (DONE occupies ≥1 cycle; `in_ready`=0 there).
- Adder path is combinational from `in_data`/`acc` to `acc` D-input; single-cycle timing through K-bit ripple.
- `out_valid` never drops without `out_ready`; outputs do not change while `out_valid`=1.

## Test plan
- K=8: beats 0x10,0x20,0x30(last), continuous valid → after 3rd fire, next cycle `out_valid`=1, `out_sum`=0x60, `out_ovf`=0, `out_count`=3, `out_trunc`=0.
- K=8: 0xFF, 0x01(last) → `out_sum`=0x00, `out_ovf`=1; then burst 0x05(last) → `out_sum`=0x05, `out_ovf`=0 (sticky cleared per burst).
- Backpressure: after DONE, `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, outputs constant; `out_ready`=1 → IDLE next cycle, pending beat fires following cycle.
- MAX_CNT=4, six beats of 0x01 with no `in_last` → first result `out_count`=4, `out_sum`=0x04, `out_trunc`=1; beats 5–6 start a new burst (count 2 on its close).
- Reset mid-burst: two beats accepted, `rst` pulsed one cycle → `out_valid` stays 0, next burst 0x07(last) yields `out_sum`=0x07, `out_count`=1.
- Single-beat burst 0xAA(last) from IDLE → `add_a`=0 during fire, `out_sum`=0xAA, `out_count`=1.

Source files
------------

// File: rtl/accum_ctrl.sv
// accum_ctrl: sequential accumulate controller wrapped around an external
// K-bit adder. It accepts unsigned operand beats over a valid/ready handshake,
// feeds the adder from the running accumulator and the incoming operand, and
// registers sum/carry back. When a burst closes, it presents the burst total
// on a valid/ready result port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_data operand, in_last closes burst
//   add_a/add_b         to adder inputs
//   add_sum/add_cout    from adder outputs
//   out_valid/out_ready result handshake
//   out_sum             burst total modulo 2^K
//   out_ovf             sticky carry-out within the burst
//   out_count           beats accepted in the burst
//   out_trunc           burst closed by MAX_CNT rather than in_last
module accum_ctrl #(
  parameter int K       = 8,
  parameter int MAX_CNT = 16,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  input  logic             in_last,
  output logic [K-1:0]     add_a,
  output logic [K-1:0]     add_b,
  input  logic [K-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [K-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             trunc_q, trunc_d;

  logic             fire;
  logic [CNT_W-1:0] new_cnt;
  logic             at_max;

  assign fire    = in_valid && in_ready;
  // Count restarts at 1 on the first beat; in ACC count_q < MAX_CNT so +1 fits.
  assign new_cnt = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
  assign at_max  = (new_cnt == CNT_W'(MAX_CNT));

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE, ACC: begin
        if (fire) begin
          acc_d   = add_sum;
          // First beat starts a fresh sticky flag; IDLE regs are already zero,
          // but this keeps the intent explicit.
          ovf_d   = (state_q == IDLE) ? add_cout : (ovf_q | add_cout);
          count_d = new_cnt;
          trunc_d = at_max && !in_last;
          state_d = (in_last || at_max) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = !rst && (state_q != DONE);
    add_a     = (state_q == IDLE) ? '0 : acc_q;
    add_b     = in_data;
    out_valid = (state_q == DONE);
    out_sum   = acc_q;
    out_ovf   = ovf_q;
    out_count = count_q;
    out_trunc = trunc_q;
  end

endmodule
